// File: rtl/red_pkg.sv
// Shared encodings for the comparison networks: the relation code carried
// between cells and the states of the serial controller.
package red_pkg;

  localparam logic [1:0] REL_IGUAL = 2'b00;
  localparam logic [1:0] REL_MAYOR = 2'b01;
  localparam logic [1:0] REL_MENOR = 2'b10;

  typedef enum logic [1:0] {
    ST_REPOSO  = 2'd0,
    ST_PROCESO = 2'd1,
    ST_FIN     = 2'd2
  } state_t;

  // One step of the right-to-left scan: a differing bit overrides the
  // relation decided by less significant bits; equal bits pass it through.
  function automatic logic [1:0] rel_step(input logic a, input logic b,
                                          input logic [1:0] rel);
    logic [1:0] r;
    r = rel;
    if (a && !b)      r = REL_MAYOR;
    else if (!a && b) r = REL_MENOR;
    return r;
  endfunction

endpackage

// File: rtl/red_serie_der_izq_celda_cmp.sv
// Single-bit comparison cell, the same function used in every stage of the
// iterative network; here it is applied once per clock.
module celda_cmp
  import red_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic [1:0] i_rel,
  output logic [1:0] o_rel
);

  always_comb begin
    o_rel = REL_IGUAL;
    o_rel = rel_step(i_a, i_b, i_rel);
  end

endmodule

// File: rtl/red_serie_der_izq.sv
// Bit-serial unsigned comparator: captures A and B on inicio, scans one bit
// pair per clock from LSB to MSB and reports the relation with a listo pulse.
module red_serie_der_izq
  import red_pkg::*;
#(
  parameter  int N  = 3,
  localparam int CW = $clog2(N + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [N-1:0] palabraA,
  input  logic [N-1:0] palabraB,
  output logic         Z,
  output logic         mayor,
  output logic         igual,
  output logic         menor,
  output logic         listo,
  output logic         ocupado
);

  state_t         r_state;
  logic [N-1:0]   r_regA;
  logic [N-1:0]   r_regB;
  logic [1:0]     r_rel;
  logic [CW-1:0]  r_cnt;
  logic           r_z;
  logic           r_mayor;
  logic           r_igual;
  logic           r_menor;
  logic           r_listo;
  logic           r_ocupado;
  logic [1:0]     w_relNext;

  celda_cmp u_celda (
    .i_a   (r_regA[0]),
    .i_b   (r_regB[0]),
    .i_rel (r_rel),
    .o_rel (w_relNext)
  );

  // Result flags decode the cell output directly on the last scan cycle so
  // they are already valid in the FIN cycle together with listo.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_REPOSO;
      r_regA    <= '0;
      r_regB    <= '0;
      r_rel     <= REL_IGUAL;
      r_cnt     <= '0;
      r_z       <= 1'b0;
      r_mayor   <= 1'b0;
      r_igual   <= 1'b0;
      r_menor   <= 1'b0;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_listo <= 1'b0;
      case (r_state)
        ST_REPOSO: begin
          r_ocupado <= 1'b0;
          if (inicio) begin
            r_regA    <= palabraA;
            r_regB    <= palabraB;
            r_rel     <= REL_IGUAL;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_state   <= ST_PROCESO;
          end
        end
        ST_PROCESO: begin
          r_rel  <= w_relNext;
          r_regA <= r_regA >> 1;
          r_regB <= r_regB >> 1;
          r_cnt  <= r_cnt + CW'(1);
          if (r_cnt == CW'(N - 1)) begin
            r_state   <= ST_FIN;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b1;
            r_mayor   <= (w_relNext == REL_MAYOR);
            r_igual   <= (w_relNext == REL_IGUAL);
            r_menor   <= (w_relNext == REL_MENOR);
            r_z       <= (w_relNext == REL_MAYOR);
          end
        end
        ST_FIN: begin
          if (inicio) begin
            r_regA    <= palabraA;
            r_regB    <= palabraB;
            r_rel     <= REL_IGUAL;
            r_cnt     <= '0;
            r_ocupado <= 1'b1;
            r_state   <= ST_PROCESO;
          end else begin
            r_ocupado <= 1'b0;
            r_state   <= ST_REPOSO;
          end
        end
        default: begin
          r_ocupado <= 1'b0;
          r_state   <= ST_REPOSO;
        end
      endcase
    end
  end

  assign Z       = r_z;
  assign mayor   = r_mayor;
  assign igual   = r_igual;
  assign menor   = r_menor;
  assign listo   = r_listo;
  assign ocupado = r_ocupado;

endmodule

// File: tb/tb_red_serie_der_izq.sv
// Scoreboard bench for the serial comparator: each accepted start pushes the
// expected relation, and every listo pulse pops and compares one entry.
module tb_red_serie_der_izq;
  import red_pkg::*;

  localparam int N = 3;

  typedef struct {
    logic z;
    logic mayor;
    logic igual;
    logic menor;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         inicio = 1'b0;
  logic [N-1:0] palabraA = '0;
  logic [N-1:0] palabraB = '0;
  logic         Z, mayor, igual, menor, listo, ocupado;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  red_serie_der_izq #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .inicio   (inicio),
    .palabraA (palabraA),
    .palabraB (palabraB),
    .Z        (Z),
    .mayor    (mayor),
    .igual    (igual),
    .menor    (menor),
    .listo    (listo),
    .ocupado  (ocupado)
  );

  always #5 clk = ~clk;

  // Every comparison in the bench funnels through here so the counts stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference relation of the low k bits, derived from plain unsigned compare.
  function automatic logic [1:0] refRel(input logic [N-1:0] a,
                                        input logic [N-1:0] b, input int k);
    logic [N-1:0] mask;
    mask = (N'(1) << k) - N'(1);
    if ((a & mask) > (b & mask)) return REL_MAYOR;
    if ((a & mask) < (b & mask)) return REL_MENOR;
    return REL_IGUAL;
  endfunction

  // Called at a negedge: drives one start cycle and records the expected result.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.z     = (a > b);
    e.mayor = (a > b);
    e.igual = (a == b);
    e.menor = (a < b);
    sb.push_back(e);
    inicio   = 1'b1;
    palabraA = a;
    palabraB = b;
    @(negedge clk);
    inicio = 1'b0;
  endtask

  // Waits for listo with a bounded budget; lat counts negedges since the start drive.
  task automatic waitListo(input int start, output int lat);
    lat = start;
    while (!listo && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!listo) checkOutput("listoTimeout", {31'd0, listo}, 32'd1);
  endtask

  // Scoreboard consumer: one pop per listo pulse, spurious pulses are flagged.
  always @(negedge clk) begin
    if (listo) begin
      if (sb.size() == 0) begin
        checkOutput("spuriousListo", {31'd0, listo}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("Z", {31'd0, Z}, {31'd0, e.z});
        checkOutput("mayor", {31'd0, mayor}, {31'd0, e.mayor});
        checkOutput("igual", {31'd0, igual}, {31'd0, e.igual});
        checkOutput("menor", {31'd0, menor}, {31'd0, e.menor});
        checkOutput("oneHot", 32'(mayor) + 32'(igual) + 32'(menor), 32'd1);
        checkOutput("ocupadoInFin", {31'd0, ocupado}, 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstZ", {31'd0, Z}, 32'd0);
    checkOutput("rstFlags", {29'd0, mayor, igual, menor}, 32'd0);
    checkOutput("rstListo", {31'd0, listo}, 32'd0);
    checkOutput("rstOcupado", {31'd0, ocupado}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // A=001 B=010: ocupado for N cycles, listo on the (N+1)th negedge
    applyStimulus(3'b001, 3'b010);
    checkOutput("t1Ocup1", {31'd0, ocupado}, 32'd1);
    @(negedge clk);
    checkOutput("t1Ocup2", {31'd0, ocupado}, 32'd1);
    @(negedge clk);
    checkOutput("t1Ocup3", {31'd0, ocupado}, 32'd1);
    waitListo(3, lat);
    checkOutput("t1Latency", lat, N + 1);
    @(negedge clk);
    checkOutput("t1ListoPulse", {31'd0, listo}, 32'd0);
    checkOutput("t1HoldMenor", {31'd0, menor}, 32'd1);

    // A=110 B=101: MENOR after bit0, overridden to MAYOR at bit1
    applyStimulus(3'b110, 3'b101);
    checkOutput("t2HoldOnStart", {31'd0, menor}, 32'd1);
    @(negedge clk);
    checkOutput("t2RelBit0", {30'd0, dut.r_rel}, {30'd0, refRel(3'b110, 3'b101, 1)});
    @(negedge clk);
    checkOutput("t2RelBit1", {30'd0, dut.r_rel}, {30'd0, refRel(3'b110, 3'b101, 2)});
    waitListo(3, lat);
    checkOutput("t2Latency", lat, N + 1);
    @(negedge clk);

    // Equal operands at both extremes
    applyStimulus(3'b111, 3'b111);
    waitListo(1, lat);
    checkOutput("t3aLatency", lat, N + 1);
    @(negedge clk);
    applyStimulus(3'b000, 3'b000);
    waitListo(1, lat);
    checkOutput("t3bLatency", lat, N + 1);
    repeat (3) @(negedge clk);
    checkOutput("t3SbDrained", sb.size(), 0);

    // Start ignored in PROCESO, then back-to-back start held through FIN
    applyStimulus(3'b011, 3'b001);
    @(negedge clk);
    inicio = 1'b1;
    palabraA = 3'b111;
    palabraB = 3'b000;
    @(negedge clk);
    inicio = 1'b0;
    waitListo(3, lat);
    checkOutput("t4Latency", lat, N + 1);
    applyStimulus(3'b000, 3'b100);
    checkOutput("t4B2bOcup", {31'd0, ocupado}, 32'd1);
    waitListo(1, lat);
    checkOutput("t4B2bLatency", lat, N + 1);
    repeat (3) @(negedge clk);
    checkOutput("t4SbDrained", sb.size(), 0);

    // Reset in PROCESO cycle 2 aborts without listo
    applyStimulus(3'b100, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    checkOutput("t5Outputs", {26'd0, Z, mayor, igual, menor, listo, ocupado}, 32'd0);
    checkOutput("t5State", {30'd0, dut.r_state}, {30'd0, ST_REPOSO});
    repeat (6) @(negedge clk);
    applyStimulus(3'b100, 3'b000);
    waitListo(1, lat);
    checkOutput("t5Latency", lat, N + 1);
    @(negedge clk);

    // Exhaustive sweep against the scoreboard model
    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        applyStimulus(N'(a), N'(b));
        waitListo(1, lat);
        @(negedge clk);
      end
    end
    repeat (3) @(negedge clk);
    checkOutput("finalSbEmpty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
